// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: user-port FSM encoding, address field layout, burst length.
package sdram_pkg;

    // Linear word address layout: {bank, row, col}
    localparam int unsigned AddrWidth = 25;
    localparam int unsigned DataWidth = 16;
    localparam int unsigned BankWidth = 2;
    localparam int unsigned RowWidth  = 13;
    localparam int unsigned ColWidth  = 10;
    localparam int unsigned BankLsb   = 23;
    localparam int unsigned RowLsb    = 10;
    localparam int unsigned ColLsb    = 0;

    // Matches mode-register burst length 8
    localparam int unsigned BurstLenDefault = 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWfill  = 3'd1,
        StWreq   = 3'd2,
        StWburst = 3'd3,
        StRreq   = 3'd4,
        StRburst = 3'd5,
        StRdrain = 3'd6
    } user_port_state_e;

endpackage

// File: rtl/sdram_burst_buf.sv
// Small burst buffer: synchronous write, asynchronous read, contents are not reset.
module sdram_burst_buf #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(Depth)-1:0] widx,
    input  logic [Width-1:0]         wdat,
    input  logic [$clog2(Depth)-1:0] ridx,
    output logic [Width-1:0]         rdat
);

    logic [Width-1:0] mem [Depth];

    // Plain storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdat;
        end
    end

    assign rdat = mem[ridx];

endmodule

// File: rtl/sdram_user_port.sv
// User-side burst port for the SDRAM controller: buffers one 8-word burst per command,
// issues the write/read request and hands data between user and controller.
module sdram_user_port
    import sdram_pkg::*;
#(
    parameter int unsigned BURST_LEN = BurstLenDefault,
    parameter int unsigned TIMEOUT   = 2047
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // User command
    input  logic                 cmd_valid,
    input  logic                 cmd_write,
    input  logic [AddrWidth-1:0] cmd_addr,
    output logic                 cmd_ready,
    // User write data
    input  logic                 wdata_valid,
    input  logic [DataWidth-1:0] wdata,
    output logic                 wdata_ready,
    // User read data
    output logic                 rdata_valid,
    output logic [DataWidth-1:0] rdata,
    input  logic                 rdata_ready,
    // Status
    output logic                 busy,
    output logic                 err,
    // Controller side
    output logic                 wr_en,
    output logic                 rd_en,
    output logic [BankWidth-1:0] bank_addr,
    output logic [RowWidth-1:0]  row_addr,
    output logic [ColWidth-1:0]  col_addr,
    output logic [DataWidth-1:0] wr_data,
    input  logic                 wrdata_vld,
    input  logic [DataWidth-1:0] rd_data,
    input  logic                 rddata_vld
);

    localparam int unsigned PtrW  = $clog2(BURST_LEN);
    localparam int unsigned TcntW = $clog2(TIMEOUT + 1);
    localparam logic [PtrW-1:0]     LastIdx  = PtrW'(BURST_LEN - 1);
    localparam logic [TcntW-1:0]    LastTcnt = TcntW'(TIMEOUT - 1);
    // Column is burst-aligned: low log2(BURST_LEN) bits forced to zero
    localparam logic [ColWidth-1:0] ColMask  = ~ColWidth'(BURST_LEN - 1);

    user_port_state_e state_q;
    logic [PtrW-1:0]  wptr_q;   // fill index for wbuf, capture index for rbuf
    logic [PtrW-1:0]  beat_q;   // write-burst beat, saturating at the last word
    logic [PtrW-1:0]  rptr_q;   // drain index for rbuf
    logic [TcntW-1:0] tcnt_q;   // request/gap timeout counter

    logic wbuf_we;
    logic rbuf_we;

    assign wbuf_we = (state_q == StWfill) && wdata_valid && wdata_ready;
    assign rbuf_we = rddata_vld && ((state_q == StRreq) || (state_q == StRburst));

    sdram_burst_buf #(
        .Depth (BURST_LEN),
        .Width (DataWidth)
    ) u_wbuf (
        .clk  (clk),
        .we   (wbuf_we),
        .widx (wptr_q),
        .wdat (wdata),
        .ridx (beat_q),
        .rdat (wr_data)
    );

    sdram_burst_buf #(
        .Depth (BURST_LEN),
        .Width (DataWidth)
    ) u_rbuf (
        .clk  (clk),
        .we   (rbuf_we),
        .widx (wptr_q),
        .wdat (rd_data),
        .ridx (rptr_q),
        .rdat (rdata)
    );

    // Port FSM with all handshake, request and status outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cmd_ready   <= 1'b0;
            wdata_ready <= 1'b0;
            rdata_valid <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            bank_addr   <= '0;
            row_addr    <= '0;
            col_addr    <= '0;
            wptr_q      <= '0;
            beat_q      <= '0;
            rptr_q      <= '0;
            tcnt_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        // Address is held until the next accepted command
                        bank_addr <= cmd_addr[BankLsb +: BankWidth];
                        row_addr  <= cmd_addr[RowLsb +: RowWidth];
                        col_addr  <= cmd_addr[ColLsb +: ColWidth] & ColMask;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        tcnt_q    <= '0;
                        if (cmd_write) begin
                            state_q     <= StWfill;
                            wdata_ready <= 1'b1;
                        end else begin
                            state_q <= StRreq;
                            rd_en   <= 1'b1;
                        end
                    end
                end
                StWfill: begin
                    if (wdata_valid && wdata_ready) begin
                        if (wptr_q == LastIdx) begin
                            wptr_q      <= '0;
                            wdata_ready <= 1'b0;
                            wr_en       <= 1'b1;
                            state_q     <= StWreq;
                        end else begin
                            wptr_q <= wptr_q + 1'b1;
                        end
                    end
                end
                StWreq: begin
                    if (wrdata_vld) begin
                        wr_en   <= 1'b0;
                        state_q <= StWburst;
                        beat_q  <= (beat_q == LastIdx) ? beat_q : beat_q + 1'b1;
                    end else if (tcnt_q == LastTcnt) begin
                        wr_en     <= 1'b0;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        tcnt_q    <= '0;
                        state_q   <= StIdle;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                StWburst: begin
                    // Controller holds wrdata_vld longer than the burst; repeat the last word
                    if (wrdata_vld) begin
                        beat_q <= (beat_q == LastIdx) ? beat_q : beat_q + 1'b1;
                    end else begin
                        beat_q    <= '0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                StRreq: begin
                    if (rddata_vld) begin
                        rd_en   <= 1'b0;
                        wptr_q  <= PtrW'(1);
                        tcnt_q  <= '0;
                        state_q <= StRburst;
                    end else if (tcnt_q == LastTcnt) begin
                        rd_en     <= 1'b0;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        tcnt_q    <= '0;
                        state_q   <= StIdle;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                StRburst: begin
                    if (rddata_vld) begin
                        if (wptr_q == LastIdx) begin
                            wptr_q      <= '0;
                            rptr_q      <= '0;
                            rdata_valid <= 1'b1;
                            state_q     <= StRdrain;
                        end else begin
                            wptr_q <= wptr_q + 1'b1;
                        end
                    end else if (tcnt_q == LastTcnt) begin
                        // Short burst: abandon the partially filled read buffer
                        wptr_q    <= '0;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        tcnt_q    <= '0;
                        state_q   <= StIdle;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                StRdrain: begin
                    if (rdata_valid && rdata_ready) begin
                        if (rptr_q == LastIdx) begin
                            rptr_q      <= '0;
                            rdata_valid <= 1'b0;
                            busy        <= 1'b0;
                            cmd_ready   <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            rptr_q <= rptr_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/sdram_user_port.md
SDRAM_USER_PORT -- requirements
Module: sdram_user_port

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8, the number of 16-bit words per SDRAM burst (matches mode-register burst length 8).
REQ-002 SHALL have parameter TIMEOUT, default 2047, the maximum cycles to wait for controller data-valid before aborting.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: `clk` in, 1 bit, 100 MHz system clock; `rst_n` in, 1 bit, reset.
REQ-004 SHALL have the user command ports: `cmd_valid` in 1 (request present); `cmd_write` in 1 (1=write, 0=read); `cmd_addr` in 25 (linear word address); `cmd_ready` out 1 (command accepted).
REQ-005 SHALL have the user write-data ports: `wdata_valid` in 1; `wdata` in 16; `wdata_ready` out 1.
REQ-006 SHALL have the user read-data ports: `rdata_valid` out 1; `rdata` out 16; `rdata_ready` in 1.
REQ-007 SHALL have the status ports: `busy` out 1 (not IDLE); `err` out 1 (sticky timeout flag).
REQ-008 SHALL have the controller-side outputs: `wr_en` 1; `rd_en` 1; `bank_addr` 2; `row_addr` 13; `col_addr` 10; `wr_data` 16.
REQ-009 SHALL have the controller-side inputs: `wrdata_vld` 1; `rd_data` 16; `rddata_vld` 1.

Function
REQ-010 SHALL map addresses as bank=cmd_addr[24:23], row=[22:10], col=[9:0], with col[2:0] forced to 0 (burst-aligned).
REQ-011 SHALL implement the FSM states IDLE, WFILL, WREQ, WBURST, RREQ, RBURST, RDRAIN.
REQ-012 SHALL, in IDLE, assert cmd_ready=1; on cmd_valid&&cmd_ready, latch the address, then go to WFILL if cmd_write else RREQ; cmd_ready=0 in all other states.
REQ-013 SHALL, in WFILL, assert wdata_ready=1 and store wdata into wbuf[wptr] on each wdata_valid&&wdata_ready; after BURST_LEN words, go to WREQ; wdata_ready=0 elsewhere.
REQ-014 SHALL hold wr_en=1 in WREQ; on the first cycle with wrdata_vld=1, deassert wr_en (registered, next cycle) and go to WBURST.
REQ-015 SHALL drive wr_data combinationally as wbuf[beat], where beat=0 on the first wrdata_vld cycle and increments each wrdata_vld cycle, saturating at BURST_LEN-1 (wrdata_vld lasts 10 cycles; beats 8-9 repeat word 7).
REQ-016 SHALL leave WBURST for IDLE on the first cycle with wrdata_vld=0.
REQ-017 SHALL hold rd_en=1 in RREQ; on the first rddata_vld=1, store rd_data into rbuf[0], deassert rd_en, and go to RBURST.
REQ-018 SHALL, in RBURST, store rd_data into rbuf[n] on each rddata_vld cycle; after BURST_LEN words, go to RDRAIN.
REQ-019 SHALL, in RDRAIN, present rdata=rbuf[rptr] with rdata_valid=1, advancing rptr on rdata_valid&&rdata_ready; after the last word is taken, go to IDLE. rdata_valid=0 elsewhere.
REQ-020 SHALL hold bank/row/col_addr stable from command accept until leaving WBURST/RBURST, since the controller samples the column late.
REQ-021 SHALL never assert wr_en and rd_en together.
REQ-022 SHALL count cycles in WREQ/RREQ; on reaching TIMEOUT, deassert the request, set err=1, and return to IDLE (read buffer discarded).
REQ-023 SHALL ignore wrdata_vld/rddata_vld arriving in any state other than WREQ/WBURST/RREQ/RBURST.
REQ-024 SHALL, if fewer than BURST_LEN rddata_vld cycles occur before a valid gap, stay in RBURST until TIMEOUT, then set err.

Reset
REQ-025 SHALL, on rst_n=0 at any time including mid-burst: state=IDLE, all pointers/counters=0, wr_en=rd_en=0, addresses=0, wr_data follows wbuf[0], cmd_ready=0 during reset then 1 from the first post-reset cycle, wdata_ready=rdata_valid=busy=err=0.
REQ-026 SHALL not reset buffer contents (wbuf/rbuf are plain storage).
REQ-027 SHALL leave err cleared only by reset.

Structure
REQ-028 SHALL place the state encoding, address-field widths/offsets, and BURST_LEN default in the shared SDRAM package, which the controller also uses.
REQ-029 SHALL implement the 8x16 write and read buffers as one reusable sub-module, sdram_burst_buf (sync write, async read, index ports).

Verification
REQ-030 SHALL cover: write to addr 0x0000010, data 0x1000..0x1007; controller model asserts wrdata_vld 10 cycles -> wr_data sequence 1000..1007,1007,1007; bank=0, row=0, col=0x010; wr_en drops after first vld.
REQ-031 SHALL cover: read at addr 0x1FFFFFF -> bank=3, row=0x1FFF, col=0x3F8; 8 rd_data words A0..A7 -> rdata A0..A7 in order with rdata_ready toggling 1/0.
REQ-032 SHALL cover: rdata_ready=0 for 20 cycles in RDRAIN -> rdata_valid stays 1, rdata=A0 stable, cmd_ready=0.
REQ-033 SHALL cover: no wrdata_vld after WREQ -> err=1 after exactly TIMEOUT cycles, wr_en=0, state IDLE, cmd_ready=1.
REQ-034 SHALL cover: rst_n pulsed low at beat 4 of a read burst -> all outputs at reset values next cycle; a new write then completes normally.
REQ-035 SHALL cover: cmd_valid held with wdata_valid gaps (1 word every 3 cycles) -> wr_en asserted only after the 8th word is accepted.
